seg_readback: RTL and testbench

//  Reads two active-low 7-segment digit buses (HEX1:HEX0) back into an 8-bit binary value.
//  It is the receive end of the adder/seven-seg display path and is used for board loopback
//  and self-check: display outputs are wired back in, and VALUE should equal the displayed sum.

---
 rtl/seg_readback.sv | 167 ++++++++++++++++
 tb/tb_seg_readback.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_readback.sv
// seg_readback
//   Receive end of the seven-segment display loopback. Two active-low digit
//   buses are synchronised, watched until they stop changing, then decoded
//   back into an 8-bit value. Patterns that are not legal hex glyphs are
//   reported instead of decoded.
//
// Ports
//   CLOCK_50   in   1  system clock, rising edge
//   RESET_N    in   1  asynchronous active-low reset
//   HEX0_IN    in   7  low digit, active-low, bit0=a .. bit6=g (asynchronous)
//   HEX1_IN    in   7  high digit, same encoding
//   VALUE      out  8  {digit1,digit0}; changes only with VALID
//   VALID      out  1  one-cycle pulse, VALUE is new and legal
//   ERROR      out  1  one-cycle pulse, stable pattern was not a legal glyph
//   ERR_DIGIT  out  2  bit0=HEX0 illegal, bit1=HEX1 illegal; changes only with ERROR
//
// FSM states
//   state | meaning
//   WAIT  | counting consecutive unchanged samples
//   EMIT  | one cycle: VALID or ERROR pulse is on the outputs
//   HOLD  | pattern already reported, waiting for it to change
module seg_readback #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [6:0] HEX0_IN,
    input  logic [6:0] HEX1_IN,
    output logic [7:0] VALUE,
    output logic       VALID,
    output logic       ERROR,
    output logic [1:0] ERR_DIGIT
);

    localparam logic [13:0] BLANK     = 14'h3FFF;
    localparam logic [7:0]  COUNT_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [13:0] sync_meta;
    logic [13:0] sync_pat;     // S
    logic [13:0] sample_pat;   // P
    logic [13:0] emit_pat;     // pattern being reported this EMIT
    logic [13:0] last_pat;     // last-decoded pattern
    logic        last_known;
    logic [7:0]  count;

    logic        pat_changed;
    logic        hold_changed;
    logic        start_emit;

    logic        legal0;
    logic        legal1;
    logic [3:0]  nib0;
    logic [3:0]  nib1;

    // Returns {legal, nibble} for one active-low digit.
    function automatic logic [4:0] decode_digit(input logic [6:0] seg_n);
        logic [6:0] seg;
        logic [4:0] res;
        seg = ~seg_n;
        case (seg)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

    assign {legal0, nib0} = decode_digit(sample_pat[6:0]);
    assign {legal1, nib1} = decode_digit(sample_pat[13:7]);

    assign pat_changed  = (sync_pat != sample_pat);
    // Compared on S, not P, so a single changed sample leaves HOLD.
    assign hold_changed = (state == HOLD) && (!last_known || (sync_pat != last_pat));
    assign start_emit   = (state == WAIT) && (count == COUNT_MAX);

    // Synchroniser, sample register and stability counter.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_meta  <= BLANK;
            sync_pat   <= BLANK;
            sample_pat <= BLANK;
            count      <= 8'd0;
        end else begin
            sync_meta  <= {HEX1_IN, HEX0_IN};
            sync_pat   <= sync_meta;
            sample_pat <= sync_pat;
            if (pat_changed || hold_changed) begin
                count <= 8'd0;
            end else if (count != COUNT_MAX) begin
                count <= count + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (count == COUNT_MAX) state_next = EMIT;
            EMIT:    state_next = HOLD;
            HOLD:    if (hold_changed) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // Outputs are registered on the WAIT->EMIT edge so the pulse and the new
    // VALUE / ERR_DIGIT appear together during the EMIT cycle.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            VALUE      <= 8'h00;
            VALID      <= 1'b0;
            ERROR      <= 1'b0;
            ERR_DIGIT  <= 2'b00;
            emit_pat   <= BLANK;
            last_pat   <= BLANK;
            last_known <= 1'b0;
        end else begin
            VALID <= 1'b0;
            ERROR <= 1'b0;
            if (start_emit) begin
                emit_pat <= sample_pat;
                if (legal0 && legal1) begin
                    VALID <= 1'b1;
                    VALUE <= {nib1, nib0};
                end else begin
                    ERROR     <= 1'b1;
                    ERR_DIGIT <= {~legal1, ~legal0};
                end
            end
            if (state == EMIT) begin
                last_pat   <= emit_pat;
                last_known <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_readback.sv
// tb_seg_readback
//   Directed loopback bench for seg_readback: step, glitch, illegal-glyph,
//   full glyph sweep, mid-count reset and repeated-pattern scenarios.
module tb_seg_readback;

    localparam int SC = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [6:0] HEX0_IN;
    logic [6:0] HEX1_IN;
    logic [7:0] VALUE;
    logic       VALID;
    logic       ERROR;
    logic [1:0] ERR_DIGIT;

    logic [6:0] seg [16];

    int n_checks = 0;
    int n_pass   = 0;

    seg_readback #(.STABLE_CYCLES(SC)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .HEX0_IN   (HEX0_IN),
        .HEX1_IN   (HEX1_IN),
        .VALUE     (VALUE),
        .VALID     (VALID),
        .ERROR     (ERROR),
        .ERR_DIGIT (ERR_DIGIT)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_pair(input int d1, input int d0);
        @(negedge CLOCK_50);
        HEX1_IN = ~seg[d1];
        HEX0_IN = ~seg[d0];
    endtask

    // Runs n cycles, sampling 1 time unit after each rising edge.
    task automatic run_window(input int n, output int nv, output int ne, output int nboth,
                              output int first, output logic [7:0] val, output logic [1:0] ed);
        nv = 0; ne = 0; nboth = 0; first = -1; val = 8'hxx; ed = 2'bxx;
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (VALID && ERROR) nboth++;
            if (VALID) begin
                if (first < 0) first = i;
                nv++;
                val = VALUE;
            end
            if (ERROR) begin
                if (first < 0) first = i;
                ne++;
                ed = ERR_DIGIT;
            end
        end
    endtask

    initial begin
        int nv, ne, nb, first;
        logic [7:0] val;
        logic [1:0] ed;

        seg[0]  = 7'h3F; seg[1]  = 7'h06; seg[2]  = 7'h5B; seg[3]  = 7'h4F;
        seg[4]  = 7'h66; seg[5]  = 7'h6D; seg[6]  = 7'h7D; seg[7]  = 7'h07;
        seg[8]  = 7'h7F; seg[9]  = 7'h6F; seg[10] = 7'h77; seg[11] = 7'h7C;
        seg[12] = 7'h39; seg[13] = 7'h5E; seg[14] = 7'h79; seg[15] = 7'h71;

        // 1: reset, then "23" steady
        RESET_N = 1'b0;
        HEX1_IN = ~seg[2];
        HEX0_IN = ~seg[3];
        #45;
        check("rst_value", VALUE, 8'h00);
        check("rst_valid", VALID, 1'b0);
        check("rst_error", ERROR, 1'b0);
        check("rst_errdig", ERR_DIGIT, 2'b00);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        run_window(20, nv, ne, nb, first, val, ed);
        check("t1_nvalid", nv, 1);
        check("t1_nerror", ne, 0);
        check("t1_latency", first, SC + 3);
        check("t1_value", val, 8'h23);
        check("t1_both", nb, 0);

        // 2: toggle HEX0 3/4 every 3 cycles, then hold "4"
        for (int t = 0; t < 14; t++) begin
            drive_pair(2, (t % 2 == 0) ? 4 : 3);
            run_window(3, nv, ne, nb, first, val, ed);
            check("t2_quiet", nv + ne, 0);
        end
        drive_pair(2, 4);
        run_window(12, nv, ne, nb, first, val, ed);
        check("t2_nvalid", nv, 1);
        check("t2_nerror", ne, 0);
        check("t2_value", val, 8'h24);

        // 3: HEX0 blank, HEX1 "0"
        @(negedge CLOCK_50);
        HEX1_IN = ~seg[0];
        HEX0_IN = 7'h7F;
        run_window(12, nv, ne, nb, first, val, ed);
        check("t3_nerror", ne, 1);
        check("t3_nvalid", nv, 0);
        check("t3_errdig", ed, 2'b01);
        check("t3_value_held", VALUE, 8'h24);

        // 4: sweep every legal glyph pair
        for (int d1 = 0; d1 < 16; d1++) begin
            for (int d0 = 0; d0 < 16; d0++) begin
                drive_pair(d1, d0);
                run_window(10, nv, ne, nb, first, val, ed);
                check("t4_count", {nv[15:0], ne[15:0]}, {16'd1, 16'd0});
                check("t4_value", val, {d1[3:0], d0[3:0]});
            end
        end

        // 5: reset two cycles after a step, release onto a blank bus
        drive_pair(7, 7);
        run_window(2, nv, ne, nb, first, val, ed);
        check("t5_pre_quiet", nv + ne, 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        #1;
        check("t5_rst_value", VALUE, 8'h00);
        check("t5_rst_valid", VALID, 1'b0);
        check("t5_rst_error", ERROR, 1'b0);
        check("t5_rst_errdig", ERR_DIGIT, 2'b00);
        HEX1_IN = 7'h7F;
        HEX0_IN = 7'h7F;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("t5_in_rst_quiet", VALID | ERROR, 1'b0);
        RESET_N = 1'b1;
        run_window(15, nv, ne, nb, first, val, ed);
        check("t5_nerror", ne, 1);
        check("t5_nvalid", nv, 0);
        check("t5_errdig", ed, 2'b11);
        check("t5_value", VALUE, 8'h00);

        // 6: "15" -> "16" -> "15"
        drive_pair(1, 5);
        run_window(8, nv, ne, nb, first, val, ed);
        check("t6_a_n", nv, 1);
        check("t6_a_lat", first, SC + 3);
        check("t6_a_val", val, 8'h15);
        drive_pair(1, 6);
        run_window(8, nv, ne, nb, first, val, ed);
        check("t6_b_n", nv, 1);
        check("t6_b_val", val, 8'h16);
        drive_pair(1, 5);
        run_window(8, nv, ne, nb, first, val, ed);
        check("t6_c_n", nv, 1);
        check("t6_c_val", val, 8'h15);
        // Held forever: no further pulse
        run_window(30, nv, ne, nb, first, val, ed);
        check("t6_held_quiet", nv + ne, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
